product_accumulator: RTL

Downstream consumer of the sequential `multiplier` stage. It accepts a stream of `2*N`-bit products over a valid/ready handshake and sums each group of `LENGTH` consecutive products (a dot-product reduction). It presents each finished sum to the next stage over a second valid/ready handshake, and flags arithmetic overflow.

---
 rtl/product_accumulator_pkg.sv | 15 +
 rtl/saturating_adder.sv | 23 ++
 rtl/product_accumulator.sv | 79 +++++++
 3 files changed

// File: rtl/product_accumulator_pkg.sv
// Shared types for the product accumulator: FSM state encoding and the
// helper that sizes the group-element counter.
package product_accumulator_pkg;

    typedef enum logic [0:0] {
        S_ACCUM  = 1'b0,
        S_OUTPUT = 1'b1
    } acc_state_t;

    // The counter must be able to hold LENGTH itself, not just LENGTH-1.
    function automatic int count_width(input int length);
        return $clog2(length + 1);
    endfunction

endpackage

// File: rtl/saturating_adder.sv
// Combinational W-bit unsigned adder with carry-out. Clamps the result to
// all-ones on carry when PRODUCT_ACCUMULATOR_SATURATE_EN is defined, else wraps.
module saturating_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         carry
);

    logic [W:0] full_sum;

    assign full_sum = {1'b0, a} + {1'b0, b};
    assign carry    = full_sum[W];

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    assign result = carry ? {W{1'b1}} : full_sum[W-1:0];
`else
    assign result = full_sum[W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Sums groups of LENGTH unsigned products and hands each sum downstream with a
// sticky overflow flag. Optional clamping: define PRODUCT_ACCUMULATOR_SATURATE_EN.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int N      = 3,
    parameter int LENGTH = 4,
    parameter int ACC_W  = 2*N + 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_i,
    input  logic [2*N-1:0]   product,
    output logic             valid_o,
    input  logic             ready_o,
    output logic [ACC_W-1:0] sum,
    output logic             overflow
);

    localparam int               CNT_W = count_width(LENGTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LENGTH - 1);

    acc_state_t       state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] count;
    logic             ovf_q;
    logic             carry;
    logic             accept;

    saturating_adder #(.W(ACC_W)) u_adder (
        .a      (acc),
        .b      (ACC_W'(product)),
        .result (acc_next),
        .carry  (carry)
    );

    // Handshake outputs depend on state only, so no input reaches them combinationally.
    assign ready_i  = (state == S_ACCUM);
    assign valid_o  = (state == S_OUTPUT);
    assign accept   = valid_i && ready_i;
    assign sum      = acc;
    assign overflow = ovf_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, and the async reset clears it without a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_ACCUM;
            acc   <= '0;
            count <= '0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                S_ACCUM: begin
                    if (accept) begin
                        acc   <= acc_next;
                        ovf_q <= ovf_q | carry;
                        count <= count + 1'b1;
                        if (count == LAST) begin
                            state <= S_OUTPUT;
                        end
                    end
                end
                S_OUTPUT: begin
                    if (ready_o) begin
                        acc   <= '0;
                        count <= '0;
                        ovf_q <= 1'b0;
                        state <= S_ACCUM;
                    end
                end
                default: state <= S_ACCUM;
            endcase
        end
    end

endmodule
